// File: rtl/retire_pkg.sv
// Shared types, widths and helpers for the retirement monitor.
package retire_pkg;

  localparam int unsigned CNT_W = 32;
  localparam int unsigned PC_W  = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2,
    ST_HUNG   = 2'd3
  } state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pc_trace_fifo.sv
// Trace FIFO of retired PCs: first-word fall-through, overwrites oldest when full.
module pc_trace_fifo
  import retire_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic [PC_W-1:0] push_pc,
  input  logic            pop,
  output logic [PC_W-1:0] head_pc,
  output logic            empty,
  output logic            ovf
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PC_W-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            full;
  logic            do_pop;
  logic            drop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO without a pop evicts the oldest entry.
  assign drop    = push && full && !do_pop;
  assign head_pc = empty ? '0 : mem[rd_ptr];

  // Pointer, occupancy and sticky overflow bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop || drop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !do_pop && !full)
        count <= count + 1'b1;
      else if (do_pop && !push)
        count <= count - 1'b1;
      if (drop)
        ovf <= 1'b1;
    end
  end

  // Storage write; no reset needed since reads are masked while empty.
  always_ff @(posedge clk) begin
    if (rst_n && push)
      mem[wr_ptr] <= push_pc;
  end

endmodule

// File: rtl/retire_monitor.sv
// Retirement monitor: counts cycles/retires/bubbles/redirects, detects halt and hang.
module retire_monitor
  import retire_pkg::*;
#(
  parameter int unsigned HANG_LIMIT  = 1000,
  parameter int unsigned HALT_REPEAT = 4,
  parameter int unsigned DEPTH       = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [PC_W-1:0]  i_pc_debug,
  input  logic             i_insn_vld,
  input  logic             i_trace_rd,
  output logic [1:0]       o_state,
  output logic             o_done,
  output logic             o_hang,
  output logic [CNT_W-1:0] o_cycle_cnt,
  output logic [CNT_W-1:0] o_retired_cnt,
  output logic [CNT_W-1:0] o_bubble_cnt,
  output logic [CNT_W-1:0] o_redirect_cnt,
  output logic [PC_W-1:0]  o_trace_pc,
  output logic             o_trace_empty,
  output logic             o_trace_ovf
);

  localparam int unsigned IR_W  = $clog2(HANG_LIMIT + 1);
  localparam int unsigned REP_W = $clog2(HALT_REPEAT);

  state_e           state, state_n;
  logic [CNT_W-1:0] cycle_cnt, cycle_cnt_n;
  logic [CNT_W-1:0] retired_cnt, retired_cnt_n;
  logic [CNT_W-1:0] bubble_cnt, bubble_cnt_n;
  logic [CNT_W-1:0] redirect_cnt, redirect_cnt_n;
  logic [PC_W-1:0]  last_pc, last_pc_n;
  logic [REP_W-1:0] rep, rep_n, rep_inc;
  logic [IR_W-1:0]  idle_run, idle_run_n, idle_inc;
  logic             trace_push;

  assign rep_inc  = rep + 1'b1;
  assign idle_inc = idle_run + 1'b1;

  // State and counter registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state        <= ST_IDLE;
      cycle_cnt    <= '0;
      retired_cnt  <= '0;
      bubble_cnt   <= '0;
      redirect_cnt <= '0;
      last_pc      <= '0;
      rep          <= '0;
      idle_run     <= '0;
    end else begin
      state        <= state_n;
      cycle_cnt    <= cycle_cnt_n;
      retired_cnt  <= retired_cnt_n;
      bubble_cnt   <= bubble_cnt_n;
      redirect_cnt <= redirect_cnt_n;
      last_pc      <= last_pc_n;
      rep          <= rep_n;
      idle_run     <= idle_run_n;
    end
  end

  // Next-state, counter update and trace push decision.
  always_comb begin
    state_n        = state;
    cycle_cnt_n    = cycle_cnt;
    retired_cnt_n  = retired_cnt;
    bubble_cnt_n   = bubble_cnt;
    redirect_cnt_n = redirect_cnt;
    last_pc_n      = last_pc;
    rep_n          = rep;
    idle_run_n     = idle_run;
    trace_push     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        // The first retire starts the run and is never a redirect.
        if (i_insn_vld) begin
          state_n       = ST_RUN;
          cycle_cnt_n   = sat_inc(cycle_cnt);
          retired_cnt_n = sat_inc(retired_cnt);
          last_pc_n     = i_pc_debug;
          rep_n         = '0;
          idle_run_n    = '0;
          trace_push    = 1'b1;
        end
      end
      ST_RUN: begin
        cycle_cnt_n = sat_inc(cycle_cnt);
        if (i_insn_vld) begin
          retired_cnt_n = sat_inc(retired_cnt);
          idle_run_n    = '0;
          last_pc_n     = i_pc_debug;
          trace_push    = 1'b1;
          if (i_pc_debug != last_pc + PC_W'(4))
            redirect_cnt_n = sat_inc(redirect_cnt);
          if (i_pc_debug == last_pc) begin
            rep_n = rep_inc;
            if (rep_inc == REP_W'(HALT_REPEAT - 1))
              state_n = ST_HALTED;
          end else begin
            rep_n = '0;
          end
        end else begin
          bubble_cnt_n = sat_inc(bubble_cnt);
          idle_run_n   = idle_inc;
          if (idle_inc == IR_W'(HANG_LIMIT))
            state_n = ST_HUNG;
        end
      end
      default: ;
    endcase
  end

  pc_trace_fifo #(
    .DEPTH(DEPTH)
  ) u_trace (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .push    (trace_push),
    .push_pc (i_pc_debug),
    .pop     (i_trace_rd),
    .head_pc (o_trace_pc),
    .empty   (o_trace_empty),
    .ovf     (o_trace_ovf)
  );

  assign o_state        = state;
  assign o_done         = (state == ST_HALTED);
  assign o_hang         = (state == ST_HUNG);
  assign o_cycle_cnt    = cycle_cnt;
  assign o_retired_cnt  = retired_cnt;
  assign o_bubble_cnt   = bubble_cnt;
  assign o_redirect_cnt = redirect_cnt;

endmodule

// File: tb/tb_retire_monitor.sv
// Scoreboard bench for retire_monitor: directed retire streams, queued expectations.
module tb_retire_monitor;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [31:0] i_pc_debug = '0;
  logic        i_insn_vld = 1'b0;
  logic        i_trace_rd = 1'b0;
  logic [1:0]  o_state;
  logic        o_done, o_hang;
  logic [31:0] o_cycle_cnt, o_retired_cnt, o_bubble_cnt, o_redirect_cnt;
  logic [31:0] o_trace_pc;
  logic        o_trace_empty, o_trace_ovf;

  retire_monitor #(
    .HANG_LIMIT(1000),
    .HALT_REPEAT(4),
    .DEPTH(8)
  ) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_pc_debug     (i_pc_debug),
    .i_insn_vld     (i_insn_vld),
    .i_trace_rd     (i_trace_rd),
    .o_state        (o_state),
    .o_done         (o_done),
    .o_hang         (o_hang),
    .o_cycle_cnt    (o_cycle_cnt),
    .o_retired_cnt  (o_retired_cnt),
    .o_bubble_cnt   (o_bubble_cnt),
    .o_redirect_cnt (o_redirect_cnt),
    .o_trace_pc     (o_trace_pc),
    .o_trace_empty  (o_trace_empty),
    .o_trace_ovf    (o_trace_ovf)
  );

  always #5 i_clk = ~i_clk;

  localparam int S_STATE = 0, S_DONE = 1, S_HANG = 2, S_CYC = 3, S_RET = 4,
                 S_BUB = 5, S_RED = 6, S_TPC = 7, S_EMPTY = 8, S_OVF = 9;

  typedef struct {
    int          sel;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] trace_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        snap = 1'b0;
  logic        fin = 1'b0;
  logic        drained = 1'b0;

  function automatic logic [31:0] pick(input int sel);
    case (sel)
      S_STATE: return {30'd0, o_state};
      S_DONE:  return {31'd0, o_done};
      S_HANG:  return {31'd0, o_hang};
      S_CYC:   return o_cycle_cnt;
      S_RET:   return o_retired_cnt;
      S_BUB:   return o_bubble_cnt;
      S_RED:   return o_redirect_cnt;
      S_TPC:   return o_trace_pc;
      S_EMPTY: return {31'd0, o_trace_empty};
      S_OVF:   return {31'd0, o_trace_ovf};
      default: return '0;
    endcase
  endfunction

  // Monitor: drains status expectations on a snapshot and checks every real pop.
  always @(negedge i_clk) begin : mon
    exp_t        e;
    logic [31:0] act;
    logic [31:0] want;
    if (snap) begin
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        act = pick(e.sel);
        n_cmp++;
        if (act !== e.val) begin
          n_bad++;
          $display("FAIL %s: got 0x%08h, want 0x%08h", e.name, act, e.val);
        end
      end
    end
    if (i_trace_rd && !o_trace_empty) begin
      n_cmp++;
      if (trace_q.size() == 0) begin
        n_bad++;
        $display("FAIL trace_pop: got 0x%08h, want no entry", o_trace_pc);
      end else begin
        want = trace_q.pop_front();
        if (o_trace_pc !== want) begin
          n_bad++;
          $display("FAIL trace_pop: got 0x%08h, want 0x%08h", o_trace_pc, want);
        end
      end
    end
    if (fin && !drained) begin
      n_cmp++;
      if (exp_q.size() != 0 || trace_q.size() != 0) begin
        n_bad++;
        $display("FAIL leftover: got %0d status / %0d trace pending, want 0 / 0",
                 exp_q.size(), trace_q.size());
      end
      drained = 1'b1;
    end
  end

  task automatic expect_val(input int sel, input string name, input logic [31:0] val);
    exp_t e;
    e.sel  = sel;
    e.val  = val;
    e.name = name;
    exp_q.push_back(e);
    snap = 1'b1;
  endtask

  // One clock with the given inputs; pending snapshots are taken on the negedge inside.
  task automatic cyc(input logic v, input logic [31:0] pc, input logic rd);
    i_insn_vld = v;
    i_pc_debug = pc;
    i_trace_rd = rd;
    @(posedge i_clk);
    #1;
    i_insn_vld = 1'b0;
    i_trace_rd = 1'b0;
    snap = 1'b0;
  endtask

  task automatic reset_seq();
    i_rst_n = 1'b0;
    cyc(1'b0, 32'h0, 1'b0);
    i_rst_n = 1'b1;
  endtask

  task automatic expect_reset_vals(input string tag);
    expect_val(S_STATE, {tag, "_state"}, 32'd0);
    expect_val(S_DONE,  {tag, "_done"},  32'd0);
    expect_val(S_HANG,  {tag, "_hang"},  32'd0);
    expect_val(S_CYC,   {tag, "_cycle"}, 32'd0);
    expect_val(S_RET,   {tag, "_retired"}, 32'd0);
    expect_val(S_BUB,   {tag, "_bubble"}, 32'd0);
    expect_val(S_RED,   {tag, "_redirect"}, 32'd0);
    expect_val(S_TPC,   {tag, "_trace_pc"}, 32'd0);
    expect_val(S_EMPTY, {tag, "_empty"}, 32'd1);
    expect_val(S_OVF,   {tag, "_ovf"}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    reset_seq();
    expect_reset_vals("rst");

    // Sequential retires then two bubbles
    reset_seq();
    cyc(1'b1, 32'h0, 1'b0);
    cyc(1'b1, 32'h4, 1'b0);
    cyc(1'b1, 32'h8, 1'b0);
    cyc(1'b0, 32'h0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0);
    expect_val(S_STATE, "seq_state", 32'd1);
    expect_val(S_CYC,   "seq_cycle", 32'd5);
    expect_val(S_RET,   "seq_retired", 32'd3);
    expect_val(S_BUB,   "seq_bubble", 32'd2);
    expect_val(S_RED,   "seq_redirect", 32'd0);
    expect_val(S_EMPTY, "seq_empty", 32'd0);

    // One redirect, then drain the trace and pop past empty
    reset_seq();
    cyc(1'b1, 32'h0, 1'b0);
    cyc(1'b1, 32'h4, 1'b0);
    cyc(1'b1, 32'h40, 1'b0);
    cyc(1'b1, 32'h44, 1'b0);
    expect_val(S_RED, "jmp_redirect", 32'd1);
    expect_val(S_RET, "jmp_retired", 32'd4);
    expect_val(S_TPC, "jmp_head", 32'h0);
    trace_q.push_back(32'h0);
    trace_q.push_back(32'h4);
    trace_q.push_back(32'h40);
    trace_q.push_back(32'h44);
    for (int i = 0; i < 4; i++) cyc(1'b0, 32'h0, 1'b1);
    expect_val(S_EMPTY, "jmp_empty", 32'd1);
    expect_val(S_TPC,   "jmp_empty_pc", 32'd0);
    cyc(1'b0, 32'h0, 1'b1);
    expect_val(S_EMPTY, "jmp_empty_pop", 32'd1);
    expect_val(S_OVF,   "jmp_ovf", 32'd0);
    expect_val(S_BUB,   "jmp_bubble", 32'd5);

    // Self-loop halt
    reset_seq();
    cyc(1'b1, 32'h10, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h20, 1'b0);
    expect_val(S_STATE, "halt_pre_state", 32'd1);
    expect_val(S_DONE,  "halt_pre_done", 32'd0);
    cyc(1'b1, 32'h20, 1'b0);
    expect_val(S_STATE, "halt_state", 32'd2);
    expect_val(S_DONE,  "halt_done", 32'd1);
    expect_val(S_RET,   "halt_retired", 32'd5);
    expect_val(S_RED,   "halt_redirect", 32'd4);
    expect_val(S_CYC,   "halt_cycle", 32'd5);
    cyc(1'b1, 32'h24, 1'b0);
    cyc(1'b1, 32'h28, 1'b0);
    expect_val(S_RET,   "halt_frozen_retired", 32'd5);
    expect_val(S_CYC,   "halt_frozen_cycle", 32'd5);
    expect_val(S_STATE, "halt_sticky", 32'd2);
    trace_q.push_back(32'h10);
    for (int i = 0; i < 4; i++) trace_q.push_back(32'h20);
    for (int i = 0; i < 5; i++) cyc(1'b0, 32'h0, 1'b1);
    expect_val(S_EMPTY, "halt_empty", 32'd1);

    // Hang exactly at the limit
    reset_seq();
    cyc(1'b1, 32'h100, 1'b0);
    for (int i = 0; i < 999; i++) cyc(1'b0, 32'h0, 1'b0);
    expect_val(S_STATE, "hang_pre_state", 32'd1);
    expect_val(S_HANG,  "hang_pre_hang", 32'd0);
    expect_val(S_BUB,   "hang_pre_bubble", 32'd999);
    cyc(1'b0, 32'h0, 1'b0);
    expect_val(S_STATE, "hang_state", 32'd3);
    expect_val(S_HANG,  "hang_hang", 32'd1);
    expect_val(S_BUB,   "hang_bubble", 32'd1000);
    expect_val(S_CYC,   "hang_cycle", 32'd1001);
    expect_val(S_DONE,  "hang_done", 32'd0);
    cyc(1'b1, 32'h104, 1'b0);
    cyc(1'b0, 32'h0, 1'b0);
    expect_val(S_RET,   "hang_frozen_retired", 32'd1);
    expect_val(S_BUB,   "hang_frozen_bubble", 32'd1000);
    expect_val(S_STATE, "hang_sticky", 32'd3);

    // A valid on the would-be limit cycle keeps RUN
    reset_seq();
    cyc(1'b1, 32'h200, 1'b0);
    for (int i = 0; i < 999; i++) cyc(1'b0, 32'h0, 1'b0);
    cyc(1'b1, 32'h204, 1'b0);
    expect_val(S_STATE, "save_state", 32'd1);
    expect_val(S_HANG,  "save_hang", 32'd0);
    expect_val(S_RET,   "save_retired", 32'd2);
    expect_val(S_RED,   "save_redirect", 32'd0);
    for (int i = 0; i < 999; i++) cyc(1'b0, 32'h0, 1'b0);
    expect_val(S_STATE, "save_run2", 32'd1);
    cyc(1'b0, 32'h0, 1'b0);
    expect_val(S_STATE, "save_hung", 32'd3);
    expect_val(S_BUB,   "save_bubble", 32'd1999);
    expect_val(S_CYC,   "save_cycle", 32'd2001);

    // Overflow: ten pushes into eight entries
    reset_seq();
    for (int i = 0; i < 10; i++) cyc(1'b1, 32'h1000 + 32'(4 * i), 1'b0);
    expect_val(S_OVF, "ovf_flag", 32'd1);
    expect_val(S_TPC, "ovf_head", 32'h1008);
    expect_val(S_RET, "ovf_retired", 32'd10);
    expect_val(S_RED, "ovf_redirect", 32'd0);
    for (int i = 2; i < 10; i++) trace_q.push_back(32'h1000 + 32'(4 * i));
    for (int i = 0; i < 8; i++) cyc(1'b0, 32'h0, 1'b1);
    expect_val(S_EMPTY, "ovf_empty", 32'd1);
    expect_val(S_OVF,   "ovf_sticky", 32'd1);

    // Full FIFO, push and pop together
    reset_seq();
    for (int i = 0; i < 8; i++) cyc(1'b1, 32'h3000 + 32'(4 * i), 1'b0);
    expect_val(S_OVF, "full_ovf_pre", 32'd0);
    expect_val(S_TPC, "full_head_pre", 32'h3000);
    trace_q.push_back(32'h3000);
    cyc(1'b1, 32'h3020, 1'b1);
    expect_val(S_OVF,   "full_ovf", 32'd0);
    expect_val(S_TPC,   "full_head", 32'h3004);
    expect_val(S_EMPTY, "full_empty", 32'd0);
    for (int i = 1; i < 9; i++) trace_q.push_back(32'h3000 + 32'(4 * i));
    for (int i = 0; i < 8; i++) cyc(1'b0, 32'h0, 1'b1);
    expect_val(S_EMPTY, "full_drained", 32'd1);
    expect_val(S_RET,   "full_retired", 32'd9);

    // Reset mid-run with a valid retire on the reset edge
    reset_seq();
    cyc(1'b1, 32'h700, 1'b0);
    cyc(1'b1, 32'h704, 1'b0);
    cyc(1'b0, 32'h0, 1'b0);
    expect_val(S_STATE, "mid_state", 32'd1);
    expect_val(S_RET,   "mid_retired", 32'd2);
    i_rst_n = 1'b0;
    cyc(1'b1, 32'h708, 1'b0);
    i_rst_n = 1'b1;
    expect_reset_vals("mid");

    @(negedge i_clk);
    #1;
    fin = 1'b1;
    for (int i = 0; i < 3; i++) if (!drained) @(negedge i_clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
